// File: rtl/bfpu_pkg.sv
// Shared definitions for the bit-vector functional unit and its issue controller.
package bfpu_pkg;

    localparam int BIT_VEC_SIZE = 64;

    typedef enum logic [2:0] {
        OP_SEL  = 3'b000,
        OP_OR   = 3'b001,
        OP_AND  = 3'b010,
        OP_ANDN = 3'b011,
        OP_XOR  = 3'b100
    } bfpu_op_e;

    // Issue controller states
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ISSUE = 2'd1;
    localparam logic [1:0] ST_WAIT  = 2'd2;

    // Legal opcodes span SEL through XOR.
    function automatic logic is_legal_op(input logic [2:0] op);
        return op <= OP_XOR;
    endfunction

endpackage

// File: rtl/bfpu_regfile.sv
// Bit-vector register file: three combinational read ports, one write port
// shared between result writeback (priority) and the external load path.
module bfpu_regfile
    import bfpu_pkg::*;
#(
    parameter int NUM_REGS = 16,
    parameter int IDX_W    = $clog2(NUM_REGS)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [IDX_W-1:0]        src1_idx,
    input  logic [IDX_W-1:0]        src2_idx,
    input  logic [IDX_W-1:0]        rd_idx,
    output logic [BIT_VEC_SIZE-1:0] src1_data,
    output logic [BIT_VEC_SIZE-1:0] src2_data,
    output logic [BIT_VEC_SIZE-1:0] rd_data,
    input  logic                    wb_en,
    input  logic [IDX_W-1:0]        wb_idx,
    input  logic [BIT_VEC_SIZE-1:0] wb_data,
    input  logic                    ld_en,
    input  logic [IDX_W-1:0]        ld_idx,
    input  logic [BIT_VEC_SIZE-1:0] ld_data
);

    logic [BIT_VEC_SIZE-1:0] regs_q [NUM_REGS];
    logic [BIT_VEC_SIZE-1:0] regs_d [NUM_REGS];

    assign src1_data = regs_q[src1_idx];
    assign src2_data = regs_q[src2_idx];
    assign rd_data   = regs_q[rd_idx];

    // Single write port; writeback wins (the controller also blocks the load then)
    always_comb begin
        regs_d = regs_q;
        if (wb_en) begin
            regs_d[wb_idx] = wb_data;
        end else if (ld_en) begin
            regs_d[ld_idx] = ld_data;
        end
    end

    // Register storage with synchronous clear
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            regs_q <= regs_d;
        end
    end

endmodule

// File: rtl/bfpu_issue.sv
// Issue controller for bfpu: accepts one instruction at a time, reads both
// operands from the local register file, pulses them into bfpu for one cycle,
// then waits (bounded) for the result and writes it back.
module bfpu_issue
    import bfpu_pkg::*;
#(
    parameter int NUM_REGS = 16,
    parameter int IDX_W    = $clog2(NUM_REGS),
    parameter int TIMEOUT  = 15
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    instr_valid,
    output logic                    instr_ready,
    input  logic [2:0]              instr_opcode,
    input  logic                    instr_choice,
    input  logic [IDX_W-1:0]        instr_src1,
    input  logic [IDX_W-1:0]        instr_src2,
    input  logic [IDX_W-1:0]        instr_dst,
    input  logic                    ld_valid,
    output logic                    ld_ready,
    input  logic [IDX_W-1:0]        ld_idx,
    input  logic [BIT_VEC_SIZE-1:0] ld_data,
    input  logic [IDX_W-1:0]        rd_idx,
    output logic [BIT_VEC_SIZE-1:0] rd_data,
    output logic [BIT_VEC_SIZE-1:0] bfpu_in_1,
    output logic [BIT_VEC_SIZE-1:0] bfpu_in_2,
    output logic                    bfpu_valid_in_1,
    output logic                    bfpu_valid_in_2,
    output logic [2:0]              bfpu_opcode,
    output logic                    bfpu_choice,
    input  logic [BIT_VEC_SIZE-1:0] bfpu_out,
    input  logic                    bfpu_valid_out,
    output logic                    busy,
    output logic                    err_illegal,
    output logic                    err_timeout,
    input  logic                    err_clr,
    output logic [15:0]             ops_done
);

    localparam int TMO_W = $clog2(TIMEOUT + 1);

    logic [1:0]              state_q, state_d;
    logic [2:0]              op_q, op_d;
    logic                    choice_q, choice_d;
    logic [IDX_W-1:0]        src1_q, src1_d;
    logic [IDX_W-1:0]        src2_q, src2_d;
    logic [IDX_W-1:0]        dst_q, dst_d;
    logic [TMO_W-1:0]        tmo_q, tmo_d;
    logic [TMO_W-1:0]        tmo_inc;
    logic                    err_illegal_q, err_illegal_d;
    logic                    err_timeout_q, err_timeout_d;
    logic [15:0]             ops_done_q, ops_done_d;
    logic [BIT_VEC_SIZE-1:0] in1_hold_q, in1_hold_d;
    logic [BIT_VEC_SIZE-1:0] in2_hold_q, in2_hold_d;

    logic                    set_illegal;
    logic                    set_timeout;
    logic                    wb_en;
    logic                    ld_en;
    logic                    in_issue;
    logic [BIT_VEC_SIZE-1:0] rf_src1;
    logic [BIT_VEC_SIZE-1:0] rf_src2;

    bfpu_regfile #(
        .NUM_REGS (NUM_REGS),
        .IDX_W    (IDX_W)
    ) u_regfile (
        .clk       (clk),
        .rst       (rst),
        .src1_idx  (src1_q),
        .src2_idx  (src2_q),
        .rd_idx    (rd_idx),
        .src1_data (rf_src1),
        .src2_data (rf_src2),
        .rd_data   (rd_data),
        .wb_en     (wb_en),
        .wb_idx    (dst_q),
        .wb_data   (bfpu_out),
        .ld_en     (ld_en),
        .ld_idx    (ld_idx),
        .ld_data   (ld_data)
    );

    assign in_issue    = (state_q == ST_ISSUE);
    assign instr_ready = (state_q == ST_IDLE);
    assign busy        = (state_q != ST_IDLE);

    // The result writeback owns the write port in its cycle; the load must retry.
    assign ld_ready = !((state_q == ST_WAIT) && bfpu_valid_out);
    assign ld_en    = ld_valid && ld_ready;

    // Operands are live from the register file only during ISSUE, held otherwise.
    assign bfpu_valid_in_1 = in_issue;
    assign bfpu_valid_in_2 = in_issue;
    assign bfpu_in_1       = in_issue ? rf_src1 : in1_hold_q;
    assign bfpu_in_2       = in_issue ? rf_src2 : in2_hold_q;
    assign bfpu_opcode     = op_q;
    assign bfpu_choice     = choice_q;

    assign err_illegal = err_illegal_q;
    assign err_timeout = err_timeout_q;
    assign ops_done    = ops_done_q;

    assign tmo_inc = tmo_q + 1'b1;

    // Next-state logic: instruction handshake, issue, bounded wait for result
    always_comb begin
        state_d     = state_q;
        op_d        = op_q;
        choice_d    = choice_q;
        src1_d      = src1_q;
        src2_d      = src2_q;
        dst_d       = dst_q;
        tmo_d       = tmo_q;
        ops_done_d  = ops_done_q;
        in1_hold_d  = in1_hold_q;
        in2_hold_d  = in2_hold_q;
        set_illegal = 1'b0;
        set_timeout = 1'b0;
        wb_en       = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (instr_valid) begin
                    if (is_legal_op(instr_opcode)) begin
                        op_d     = instr_opcode;
                        choice_d = instr_choice;
                        src1_d   = instr_src1;
                        src2_d   = instr_src2;
                        dst_d    = instr_dst;
                        state_d  = ST_ISSUE;
                    end else begin
                        // Handshake still completes; nothing is issued.
                        set_illegal = 1'b1;
                    end
                end
            end
            ST_ISSUE: begin
                in1_hold_d = rf_src1;
                in2_hold_d = rf_src2;
                tmo_d      = '0;
                state_d    = ST_WAIT;
            end
            ST_WAIT: begin
                if (bfpu_valid_out) begin
                    wb_en      = 1'b1;
                    ops_done_d = ops_done_q + 16'd1;
                    tmo_d      = '0;
                    state_d    = ST_IDLE;
                end else if (tmo_inc == TMO_W'(TIMEOUT)) begin
                    set_timeout = 1'b1;
                    tmo_d       = '0;
                    state_d     = ST_IDLE;
                end else begin
                    tmo_d = tmo_inc;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Sticky error flags: a set in the same cycle as a clear wins
    always_comb begin
        err_illegal_d = (err_illegal_q && !err_clr) || set_illegal;
        err_timeout_d = (err_timeout_q && !err_clr) || set_timeout;
    end

    // Controller state registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            op_q          <= '0;
            choice_q      <= 1'b0;
            src1_q        <= '0;
            src2_q        <= '0;
            dst_q         <= '0;
            tmo_q         <= '0;
            err_illegal_q <= 1'b0;
            err_timeout_q <= 1'b0;
            ops_done_q    <= '0;
            in1_hold_q    <= '0;
            in2_hold_q    <= '0;
        end else begin
            state_q       <= state_d;
            op_q          <= op_d;
            choice_q      <= choice_d;
            src1_q        <= src1_d;
            src2_q        <= src2_d;
            dst_q         <= dst_d;
            tmo_q         <= tmo_d;
            err_illegal_q <= err_illegal_d;
            err_timeout_q <= err_timeout_d;
            ops_done_q    <= ops_done_d;
            in1_hold_q    <= in1_hold_d;
            in2_hold_q    <= in2_hold_d;
        end
    end

endmodule

// File: tb/tb_bfpu_issue.sv
// Bench for bfpu_issue: a behavioural bfpu stub (latency 1) plus a shadow
// register model; expected writebacks go through a scoreboard queue.
module tb_bfpu_issue;
    import bfpu_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        instr_valid;
    logic        instr_ready;
    logic [2:0]  instr_opcode;
    logic        instr_choice;
    logic [3:0]  instr_src1, instr_src2, instr_dst;
    logic        ld_valid;
    logic        ld_ready;
    logic [3:0]  ld_idx;
    logic [63:0] ld_data;
    logic [3:0]  rd_idx;
    logic [63:0] rd_data;
    logic [63:0] bfpu_in_1, bfpu_in_2;
    logic        bfpu_valid_in_1, bfpu_valid_in_2;
    logic [2:0]  bfpu_opcode;
    logic        bfpu_choice;
    logic [63:0] bfpu_out;
    logic        bfpu_valid_out;
    logic        busy, err_illegal, err_timeout, err_clr;
    logic [15:0] ops_done;

    logic        stub_en;
    logic        stray_req;

    typedef struct packed {
        logic [3:0]  idx;
        logic [63:0] data;
    } sb_t;

    sb_t         sb[$];
    logic [63:0] m_regs [16];
    int          n_pass = 0;
    int          n_total = 0;

    bfpu_issue dut (
        .clk             (clk),
        .rst             (rst),
        .instr_valid     (instr_valid),
        .instr_ready     (instr_ready),
        .instr_opcode    (instr_opcode),
        .instr_choice    (instr_choice),
        .instr_src1      (instr_src1),
        .instr_src2      (instr_src2),
        .instr_dst       (instr_dst),
        .ld_valid        (ld_valid),
        .ld_ready        (ld_ready),
        .ld_idx          (ld_idx),
        .ld_data         (ld_data),
        .rd_idx          (rd_idx),
        .rd_data         (rd_data),
        .bfpu_in_1       (bfpu_in_1),
        .bfpu_in_2       (bfpu_in_2),
        .bfpu_valid_in_1 (bfpu_valid_in_1),
        .bfpu_valid_in_2 (bfpu_valid_in_2),
        .bfpu_opcode     (bfpu_opcode),
        .bfpu_choice     (bfpu_choice),
        .bfpu_out        (bfpu_out),
        .bfpu_valid_out  (bfpu_valid_out),
        .busy            (busy),
        .err_illegal     (err_illegal),
        .err_timeout     (err_timeout),
        .err_clr         (err_clr),
        .ops_done        (ops_done)
    );

    always #5 clk = ~clk;

    function automatic logic [63:0] exp_res(input logic [2:0] op, input logic ch,
                                            input logic [63:0] a, input logic [63:0] b);
        case (op)
            3'b000:  return ch ? b : a;
            3'b001:  return a | b;
            3'b010:  return a & b;
            3'b011:  return a & ~b;
            3'b100:  return a ^ b;
            default: return '0;
        endcase
    endfunction

    // bfpu stub: one-cycle latency, can be muted or made to emit a stray result
    always @(posedge clk) begin
        if (stray_req) begin
            bfpu_valid_out <= 1'b1;
            bfpu_out       <= 64'hDEAD_BEEF_DEAD_BEEF;
        end else if (stub_en && bfpu_valid_in_1 && bfpu_valid_in_2) begin
            bfpu_valid_out <= 1'b1;
            bfpu_out       <= exp_res(bfpu_opcode, bfpu_choice, bfpu_in_1, bfpu_in_2);
        end else begin
            bfpu_valid_out <= 1'b0;
        end
    end

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_load(input logic [3:0] idx, input logic [63:0] data);
        ld_valid = 1'b1;
        ld_idx   = idx;
        ld_data  = data;
        n_total++;
        if (ld_ready !== 1'b1) $display("FAIL load_ready r%0d: got %b want 1", idx, ld_ready);
        else n_pass++;
        tick();
        ld_valid = 1'b0;
        m_regs[idx] = data;
    endtask

    // Issue one instruction on the nominal 3-cycle schedule and check its writeback.
    task automatic issue_op(input logic [2:0] op, input logic ch,
                            input logic [3:0] s1, input logic [3:0] s2, input logic [3:0] d);
        sb_t e;
        instr_valid  = 1'b1;
        instr_opcode = op;
        instr_choice = ch;
        instr_src1   = s1;
        instr_src2   = s2;
        instr_dst    = d;
        n_total++;
        if (instr_ready !== 1'b1) $display("FAIL issue_ready op%0d: got %b want 1", op, instr_ready);
        else n_pass++;
        e.idx  = d;
        e.data = exp_res(op, ch, m_regs[s1], m_regs[s2]);
        sb.push_back(e);
        tick();
        instr_valid = 1'b0;
        n_total++;
        if ({bfpu_valid_in_1, bfpu_valid_in_2, bfpu_opcode} !== {2'b11, op})
            $display("FAIL issue_cycle op%0d: got v=%b%b op=%0d want v=11 op=%0d",
                     op, bfpu_valid_in_1, bfpu_valid_in_2, bfpu_opcode, op);
        else n_pass++;
        n_total++;
        if (bfpu_in_1 !== m_regs[s1] || bfpu_in_2 !== m_regs[s2])
            $display("FAIL issue_operands op%0d: got %h/%h want %h/%h",
                     op, bfpu_in_1, bfpu_in_2, m_regs[s1], m_regs[s2]);
        else n_pass++;
        tick();
        n_total++;
        if ({busy, instr_ready, bfpu_valid_in_1} !== 3'b100)
            $display("FAIL wait_cycle op%0d: got busy/ready/vin=%b%b%b want 100",
                     op, busy, instr_ready, bfpu_valid_in_1);
        else n_pass++;
        tick();
        n_total++;
        if (instr_ready !== 1'b1) $display("FAIL ready_t3 op%0d: got %b want 1", op, instr_ready);
        else n_pass++;
        e = sb.pop_front();
        m_regs[e.idx] = e.data;
        rd_idx = e.idx;
        #1;
        n_total++;
        if (rd_data !== e.data) $display("FAIL writeback r%0d: got %h want %h", e.idx, rd_data, e.data);
        else n_pass++;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        instr_valid = 1'b0; instr_opcode = '0; instr_choice = 1'b0;
        instr_src1 = '0; instr_src2 = '0; instr_dst = '0;
        ld_valid = 1'b0; ld_idx = '0; ld_data = '0; rd_idx = '0; err_clr = 1'b0;
        stub_en = 1'b1; stray_req = 1'b0;
        for (int i = 0; i < 16; i++) m_regs[i] = '0;
        tick(); tick();
        rst = 1'b0;
        n_total++;
        if ({instr_ready, busy, err_illegal, err_timeout, ld_ready} !== 5'b10001)
            $display("FAIL reset_flags: got %b want 10001",
                     {instr_ready, busy, err_illegal, err_timeout, ld_ready});
        else n_pass++;
        n_total++;
        if ({bfpu_in_1, bfpu_in_2, bfpu_valid_in_1, bfpu_valid_in_2, bfpu_opcode, bfpu_choice, ops_done} !== '0)
            $display("FAIL reset_bfpu_outs: got in=%h/%h op=%0d ops=%0d want 0",
                     bfpu_in_1, bfpu_in_2, bfpu_opcode, ops_done);
        else n_pass++;
    endtask

    task automatic test_xor();
        do_load(4'd1, 64'hFF00FF00FF00FF00);
        do_load(4'd2, 64'h0F0F0F0F0F0F0F0F);
        issue_op(3'b100, 1'b0, 4'd1, 4'd2, 4'd3);
        n_total++;
        if (rd_data !== 64'hF00FF00FF00FF00F) $display("FAIL xor_value: got %h want F00FF00FF00FF00F", rd_data);
        else n_pass++;
        n_total++;
        if (ops_done !== 16'd1) $display("FAIL xor_ops_done: got %0d want 1", ops_done);
        else n_pass++;
    endtask

    task automatic test_back_to_back();
        @(negedge clk);
        issue_op(3'b000, 1'b1, 4'd1, 4'd2, 4'd4);
        issue_op(3'b011, 1'b0, 4'd1, 4'd2, 4'd5);
        n_total++;
        if (rd_data !== 64'hF000F000F000F000) $display("FAIL andn_value: got %h want F000F000F000F000", rd_data);
        else n_pass++;
        rd_idx = 4'd4;
        #1;
        n_total++;
        if (rd_data !== 64'h0F0F0F0F0F0F0F0F) $display("FAIL sel_value: got %h want 0F0F0F0F0F0F0F0F", rd_data);
        else n_pass++;
        n_total++;
        if (ops_done !== 16'd3) $display("FAIL b2b_ops_done: got %0d want 3", ops_done);
        else n_pass++;
    endtask

    task automatic test_illegal();
        int bad;
        @(negedge clk);
        instr_valid = 1'b1; instr_opcode = 3'b110; instr_src1 = 4'd1; instr_src2 = 4'd2; instr_dst = 4'd3;
        n_total++;
        if (instr_ready !== 1'b1) $display("FAIL illegal_ready: got %b want 1", instr_ready);
        else n_pass++;
        tick();
        instr_valid = 1'b0;
        n_total++;
        if ({err_illegal, busy, bfpu_valid_in_1, bfpu_valid_in_2} !== 4'b1000)
            $display("FAIL illegal_flag: got err/busy/vin=%b%b%b%b want 1000",
                     err_illegal, busy, bfpu_valid_in_1, bfpu_valid_in_2);
        else n_pass++;
        tick();
        n_total++;
        if ({busy, bfpu_valid_in_1, ops_done} !== {2'b00, 16'd3})
            $display("FAIL illegal_noissue: got busy=%b vin=%b ops=%0d want 0 0 3", busy, bfpu_valid_in_1, ops_done);
        else n_pass++;
        bad = 0;
        for (int i = 0; i < 16; i++) begin
            rd_idx = 4'(i);
            #1;
            if (rd_data !== m_regs[i]) bad++;
        end
        @(negedge clk);
        n_total++;
        if (bad != 0) $display("FAIL illegal_regs: got %0d changed regs want 0", bad);
        else n_pass++;
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        n_total++;
        if (err_illegal !== 1'b0) $display("FAIL illegal_clr: got %b want 0", err_illegal);
        else n_pass++;
        // Set and clear in the same cycle: set wins
        instr_valid = 1'b1; instr_opcode = 3'b111; err_clr = 1'b1;
        tick();
        instr_valid = 1'b0; err_clr = 1'b0;
        n_total++;
        if (err_illegal !== 1'b1) $display("FAIL illegal_set_wins: got %b want 1", err_illegal);
        else n_pass++;
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
    endtask

    task automatic test_timeout();
        int cnt;
        stub_en = 1'b0;
        instr_valid = 1'b1; instr_opcode = 3'b100; instr_choice = 1'b0;
        instr_src1 = 4'd1; instr_src2 = 4'd2; instr_dst = 4'd7;
        tick();
        instr_valid = 1'b0;
        n_total++;
        if (bfpu_valid_in_1 !== 1'b1) $display("FAIL tmo_issue: got %b want 1", bfpu_valid_in_1);
        else n_pass++;
        cnt = 0;
        while (err_timeout !== 1'b1 && cnt < 40) begin
            tick();
            cnt++;
        end
        // 15 WAIT cycles follow ISSUE; the flag shows in the cycle after the 15th.
        n_total++;
        if (cnt != 16) $display("FAIL tmo_cycles: got %0d want 16", cnt);
        else n_pass++;
        n_total++;
        if ({instr_ready, busy} !== 2'b10) $display("FAIL tmo_idle: got ready/busy=%b%b want 10", instr_ready, busy);
        else n_pass++;
        rd_idx = 4'd7;
        #1;
        n_total++;
        if (rd_data !== m_regs[7]) $display("FAIL tmo_nowrite: got %h want %h", rd_data, m_regs[7]);
        else n_pass++;
        @(negedge clk);
        stray_req = 1'b1;
        tick();
        stray_req = 1'b0;
        tick();
        rd_idx = 4'd7;
        #1;
        n_total++;
        if ({rd_data, ops_done, busy} !== {m_regs[7], 16'd3, 1'b0})
            $display("FAIL stray_ignored: got r7=%h ops=%0d busy=%b want %h 3 0", rd_data, ops_done, busy, m_regs[7]);
        else n_pass++;
        @(negedge clk);
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        stub_en = 1'b1;
        n_total++;
        if (err_timeout !== 1'b0) $display("FAIL tmo_clr: got %b want 0", err_timeout);
        else n_pass++;
    endtask

    task automatic test_load_collision();
        sb_t e;
        // Load r1 during the ISSUE of OR r6 <- r1,r2
        instr_valid = 1'b1; instr_opcode = 3'b001; instr_choice = 1'b0;
        instr_src1 = 4'd1; instr_src2 = 4'd2; instr_dst = 4'd6;
        e.idx = 4'd6; e.data = m_regs[1] | m_regs[2];
        sb.push_back(e);
        tick();
        instr_valid = 1'b0;
        ld_valid = 1'b1; ld_idx = 4'd1; ld_data = 64'h1234_5678_9ABC_DEF0;
        n_total++;
        if (ld_ready !== 1'b1) $display("FAIL ld_issue_ready: got %b want 1", ld_ready);
        else n_pass++;
        m_regs[1] = 64'h1234_5678_9ABC_DEF0;
        tick();
        ld_valid = 1'b0;
        tick();
        e = sb.pop_front();
        m_regs[e.idx] = e.data;
        rd_idx = e.idx;
        #1;
        n_total++;
        if (rd_data !== e.data) $display("FAIL ld_old_operand: got %h want %h", rd_data, e.data);
        else n_pass++;
        rd_idx = 4'd1;
        #1;
        n_total++;
        if (rd_data !== 64'h1234_5678_9ABC_DEF0) $display("FAIL ld_new_r1: got %h want 123456789ABCDEF0", rd_data);
        else n_pass++;
        // Load during the writeback cycle of AND r8 <- r1,r2 is refused once
        @(negedge clk);
        instr_valid = 1'b1; instr_opcode = 3'b010; instr_dst = 4'd8;
        e.idx = 4'd8; e.data = m_regs[1] & m_regs[2];
        sb.push_back(e);
        tick();
        instr_valid = 1'b0;
        tick();
        ld_valid = 1'b1; ld_idx = 4'd9; ld_data = 64'hA5A5_5A5A_0000_FFFF;
        #1;
        n_total++;
        if (ld_ready !== 1'b0) $display("FAIL ld_wb_blocked: got %b want 0", ld_ready);
        else n_pass++;
        @(negedge clk);
        n_total++;
        if (ld_ready !== 1'b1) $display("FAIL ld_retry_ready: got %b want 1", ld_ready);
        else n_pass++;
        rd_idx = 4'd9;
        #1;
        n_total++;
        if (rd_data !== m_regs[9]) $display("FAIL ld_not_early: got %h want %h", rd_data, m_regs[9]);
        else n_pass++;
        @(negedge clk);
        ld_valid = 1'b0;
        m_regs[9] = 64'hA5A5_5A5A_0000_FFFF;
        #1;
        n_total++;
        if (rd_data !== m_regs[9]) $display("FAIL ld_landed: got %h want %h", rd_data, m_regs[9]);
        else n_pass++;
        e = sb.pop_front();
        m_regs[e.idx] = e.data;
        rd_idx = e.idx;
        #1;
        n_total++;
        if (rd_data !== e.data) $display("FAIL ld_wb_result: got %h want %h", rd_data, e.data);
        else n_pass++;
        @(negedge clk);
    endtask

    task automatic test_reset_mid();
        int bad;
        sb_t e;
        instr_valid = 1'b1; instr_opcode = 3'b001; instr_choice = 1'b0;
        instr_src1 = 4'd1; instr_src2 = 4'd2; instr_dst = 4'd10;
        e.idx = 4'd10; e.data = m_regs[1] | m_regs[2];
        sb.push_back(e);
        tick();
        instr_valid = 1'b0;
        tick();
        // WAIT with the result present: reset on this edge beats the writeback
        rst = 1'b1;
        tick();
        rst = 1'b0;
        void'(sb.pop_front());
        for (int i = 0; i < 16; i++) m_regs[i] = '0;
        n_total++;
        if ({instr_ready, busy, err_illegal, err_timeout, ops_done} !== {4'b1000, 16'd0})
            $display("FAIL rst_mid_flags: got ready/busy/ei/et=%b%b%b%b ops=%0d want 1000 0",
                     instr_ready, busy, err_illegal, err_timeout, ops_done);
        else n_pass++;
        n_total++;
        if ({bfpu_in_1, bfpu_in_2, bfpu_valid_in_1, bfpu_valid_in_2, bfpu_opcode, bfpu_choice} !== '0)
            $display("FAIL rst_mid_bfpu: got in=%h/%h op=%0d want 0", bfpu_in_1, bfpu_in_2, bfpu_opcode);
        else n_pass++;
        tick();
        bad = 0;
        for (int i = 0; i < 16; i++) begin
            rd_idx = 4'(i);
            #1;
            if (rd_data !== 64'd0) bad++;
        end
        @(negedge clk);
        n_total++;
        if (bad != 0) $display("FAIL rst_mid_regs: got %0d nonzero regs want 0", bad);
        else n_pass++;
        do_load(4'd1, 64'h00FF_00FF_1234_4321);
        do_load(4'd2, 64'hFFFF_0000_FFFF_0000);
        issue_op(3'b100, 1'b0, 4'd1, 4'd2, 4'd11);
        n_total++;
        if (ops_done !== 16'd1) $display("FAIL rst_mid_resume: got %0d want 1", ops_done);
        else n_pass++;
    endtask

    initial begin
        test_reset();
        test_xor();
        test_back_to_back();
        test_illegal();
        test_timeout();
        test_load_collision();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
